// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state encoding and coefficient tables for the MAC stream feeder
package mac_pkg;

    localparam logic [31:0] NAN_SENTINEL = 32'h7F90_0000;
    localparam int          COEF_COUNT   = 10;

    typedef enum logic [2:0] {
        IDLE,
        SEND_SIG,
        SIG_END,
        SEND_COEF,
        COEF_END,
        DONE
    } state_e;

    localparam logic [31:0] SELU_COEF [COEF_COUNT] = '{
        32'h3493_F27D, 32'h3638_EF1D, 32'h37D0_0D01, 32'h3950_0D01, 32'h3AB6_0B61,
        32'h3C08_8889, 32'h3D2A_AAAB, 32'h3E2A_AAAB, 32'h3F00_0000, 32'h3F80_0000
    };

    localparam logic [31:0] TANH_COEF [COEF_COUNT] = '{
        32'h2317_A4DB, 32'h274A_963B, 32'h2B57_3F9F, 32'h2F30_9231, 32'h32D7_322B,
        32'h3638_EF1D, 32'h3950_0D01, 32'h3C08_8889, 32'h3E2A_AAAB, 32'h3F80_0000
    };

    function automatic logic [31:0] coef_word(input logic tanh_sel, input logic [3:0] idx);
        if (idx >= 4'(COEF_COUNT)) return '0;
        return tanh_sel ? TANH_COEF[idx] : SELU_COEF[idx];
    endfunction

    // Sign bit is irrelevant to NaN detection, so only bits 30:0 are taken.
    function automatic logic is_nan(input logic [30:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/mac_stream_feeder_if.sv
// rtl/mac_stream_feeder_if.sv - sample input stream and MAC-side output bundle of the feeder
interface mac_stream_feeder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_valid_i;
    logic                  sample_last_i;
    logic                  sample_ready_o;
    logic                  mode;
    logic [DATA_WIDTH-1:0] signal_fifo;
    logic                  signal_wr_o;
    logic [DATA_WIDTH-1:0] coeff_fifo;
    logic                  coeff_wr_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  nan_drop_o;

    modport master (
        output sample_i, sample_valid_i, sample_last_i, mode,
        input  sample_ready_o, signal_fifo, signal_wr_o, coeff_fifo, coeff_wr_o,
        input  busy_o, done_o, nan_drop_o
    );

    modport slave (
        input  sample_i, sample_valid_i, sample_last_i, mode,
        output sample_ready_o, signal_fifo, signal_wr_o, coeff_fifo, coeff_wr_o,
        output busy_o, done_o, nan_drop_o
    );
endinterface

// File: rtl/feeder_buf.sv
// rtl/feeder_buf.sv - simple dual-port sample buffer, one write port and one asynchronous read port
module feeder_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 5
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_LINES-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_LINES-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_LINES];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/mac_stream_feeder.sv
// rtl/mac_stream_feeder.sv - buffers a sample burst, then streams samples, sentinel, coefficient table, sentinel
module mac_stream_feeder
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 5
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    mac_stream_feeder_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_LINES;
    localparam int CW    = ADDR_LINES + 1;

    state_e                state_q;
    logic [ADDR_LINES-1:0] wr_ptr_q;
    logic [CW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [3:0]            coef_idx_q;
    logic                  mode_q;
    logic [DATA_WIDTH-1:0] signal_q;
    logic [DATA_WIDTH-1:0] coeff_q;
    logic                  signal_wr_q;
    logic                  coeff_wr_q;
    logic                  done_q;
    logic                  nan_drop_q;

    logic                  accept;
    logic                  sample_nan;
    logic                  store;
    logic                  close;
    logic [CW-1:0]         count_d;
    logic [DATA_WIDTH-1:0] buf_rd_data;

    assign accept     = (state_q == IDLE) && bus.sample_valid_i;
    assign sample_nan = is_nan(bus.sample_i[30:0]);
    assign store      = accept && !sample_nan;
    assign count_d    = count_q + CW'(store);
    // A dropped NaN can still close a burst, but never an empty one.
    assign close      = accept && ((bus.sample_last_i && (count_d != '0)) || (count_d == CW'(DEPTH)));

    feeder_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_LINES (ADDR_LINES)
    ) u_buf (
        .clk_i     (clk_i),
        .wr_en_i   (store),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.sample_i),
        .rd_addr_i (rd_ptr_q[ADDR_LINES-1:0]),
        .rd_data_o (buf_rd_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            coef_idx_q  <= '0;
            mode_q      <= 1'b0;
            signal_q    <= '0;
            coeff_q     <= '0;
            signal_wr_q <= 1'b0;
            coeff_wr_q  <= 1'b0;
            done_q      <= 1'b0;
            nan_drop_q  <= 1'b0;
        end else begin
            signal_wr_q <= 1'b0;
            coeff_wr_q  <= 1'b0;
            done_q      <= 1'b0;
            nan_drop_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        nan_drop_q <= sample_nan;
                        count_q    <= count_d;
                        if (store) wr_ptr_q <= wr_ptr_q + ADDR_LINES'(1);
                        if (close) begin
                            state_q  <= SEND_SIG;
                            mode_q   <= bus.mode;
                            rd_ptr_q <= '0;
                        end
                    end
                end
                SEND_SIG: begin
                    signal_wr_q <= 1'b1;
                    if (rd_ptr_q == count_q) begin
                        signal_q <= DATA_WIDTH'(NAN_SENTINEL);
                        state_q  <= SIG_END;
                    end else begin
                        signal_q <= buf_rd_data;
                        rd_ptr_q <= rd_ptr_q + CW'(1);
                    end
                end
                SIG_END: begin
                    coeff_q    <= DATA_WIDTH'(coef_word(mode_q, 4'd0));
                    coeff_wr_q <= 1'b1;
                    coef_idx_q <= 4'd1;
                    state_q    <= SEND_COEF;
                end
                SEND_COEF: begin
                    coeff_wr_q <= 1'b1;
                    if (coef_idx_q == 4'(COEF_COUNT)) begin
                        coeff_q <= DATA_WIDTH'(NAN_SENTINEL);
                        state_q <= COEF_END;
                    end else begin
                        coeff_q    <= DATA_WIDTH'(coef_word(mode_q, coef_idx_q));
                        coef_idx_q <= coef_idx_q + 4'd1;
                    end
                end
                COEF_END: begin
                    done_q   <= 1'b1;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    state_q  <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sample_ready_o = (state_q == IDLE);
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.signal_fifo    = signal_q;
    assign bus.signal_wr_o    = signal_wr_q;
    assign bus.coeff_fifo     = coeff_q;
    assign bus.coeff_wr_o     = coeff_wr_q;
    assign bus.done_o         = done_q;
    assign bus.nan_drop_o     = nan_drop_q;
endmodule

// File: tb/tb_mac_stream_feeder.sv
// tb/tb_mac_stream_feeder.sv - scoreboard bench for the MAC stream feeder with directed bursts
module tb_mac_stream_feeder;
    localparam logic [31:0] SENT = 32'h7F90_0000;
    localparam logic [31:0] SELU_T [10] = '{
        32'h3493F27D, 32'h3638EF1D, 32'h37D00D01, 32'h39500D01, 32'h3AB60B61,
        32'h3C088889, 32'h3D2AAAAB, 32'h3E2AAAAB, 32'h3F000000, 32'h3F800000};
    localparam logic [31:0] TANH_T [10] = '{
        32'h2317A4DB, 32'h274A963B, 32'h2B573F9F, 32'h2F309231, 32'h32D7322B,
        32'h3638EF1D, 32'h39500D01, 32'h3C088889, 32'h3E2AAAAB, 32'h3F800000};
    localparam logic [31:0] T1_VEC [5] = '{
        32'hBDFCD6E9, 32'h40A00000, 32'h4094F72D, 32'hC089EE59, 32'hC07DCB09};

    typedef struct {
        int          cyc;
        logic [31:0] w;
    } ev_t;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_stream_feeder_if #(.DATA_WIDTH(32)) bus ();

    mac_stream_feeder #(.DATA_WIDTH(32), .ADDR_LINES(5)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    ev_t         sig_q[$];
    ev_t         coef_q[$];
    int          nan_q[$];
    logic [31:0] pend[$];
    logic [31:0] last_sig  = '0;
    logic [31:0] last_coef = '0;
    int          busy_from = 0;
    int          busy_to   = -1;
    int          done_cyc  = -1;
    int          e0        = 0;

    int          obs_sig_n;
    int          obs_nan_n;
    int          done_seen;
    logic [31:0] obs_coef[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sig_q.delete(); coef_q.delete(); nan_q.delete(); pend.delete();
        last_sig = '0; last_coef = '0;
        busy_to = -1; done_cyc = -1;
    endtask

    // Called #1 after the edge that accepted w; cyc is that edge's number.
    task automatic model_accept(input logic [31:0] w, input logic l);
        if (w[30:23] == 8'hFF && w[22:0] != 23'd0) nan_q.push_back(cyc);
        else pend.push_back(w);
        if ((l && pend.size() > 0) || pend.size() == 32) begin
            int n;
            n  = pend.size();
            e0 = cyc;
            for (int k = 0; k < n; k++) sig_q.push_back(ev_t'{e0 + 1 + k, pend[k]});
            sig_q.push_back(ev_t'{e0 + n + 1, SENT});
            for (int k = 0; k < 10; k++)
                coef_q.push_back(ev_t'{e0 + n + 2 + k, bus.mode ? TANH_T[k] : SELU_T[k]});
            coef_q.push_back(ev_t'{e0 + n + 12, SENT});
            done_cyc  = e0 + n + 13;
            busy_from = e0;
            busy_to   = e0 + n + 13;
            pend.delete();
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (sig_q.size() > 0 && sig_q[0].cyc == cyc) begin
                check("sig_wr", bus.signal_wr_o, 1);
                check("sig_data", bus.signal_fifo, sig_q[0].w);
                last_sig = sig_q[0].w;
                void'(sig_q.pop_front());
            end else begin
                check("sig_wr_idle", bus.signal_wr_o, 0);
                check("sig_hold", bus.signal_fifo, last_sig);
            end
            if (coef_q.size() > 0 && coef_q[0].cyc == cyc) begin
                check("coef_wr", bus.coeff_wr_o, 1);
                check("coef_data", bus.coeff_fifo, coef_q[0].w);
                last_coef = coef_q[0].w;
                void'(coef_q.pop_front());
            end else begin
                check("coef_wr_idle", bus.coeff_wr_o, 0);
                check("coef_hold", bus.coeff_fifo, last_coef);
            end
            if (nan_q.size() > 0 && nan_q[0] == cyc) begin
                check("nan_drop", bus.nan_drop_o, 1);
                void'(nan_q.pop_front());
            end else begin
                check("nan_drop_idle", bus.nan_drop_o, 0);
            end
            check("done", bus.done_o, (cyc == done_cyc) ? 1 : 0);
            check("busy", bus.busy_o, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
            check("ready", bus.sample_ready_o, (cyc >= busy_from && cyc <= busy_to) ? 0 : 1);
            if (bus.signal_wr_o) obs_sig_n++;
            if (bus.coeff_wr_o)  obs_coef.push_back(bus.coeff_fifo);
            if (bus.nan_drop_o)  obs_nan_n++;
            if (bus.done_o)      done_seen = cyc;
        end
    end

    task automatic clear_obs();
        obs_sig_n = 0; obs_nan_n = 0; done_seen = -1; obs_coef.delete();
    endtask

    task automatic send(input logic [31:0] w, input logic l);
        @(negedge clk);
        bus.sample_i = w; bus.sample_valid_i = 1'b1; bus.sample_last_i = l;
        @(posedge clk); #1;
        bus.sample_valid_i = 1'b0; bus.sample_last_i = 1'b0;
        model_accept(w, l);
    endtask

    task automatic settle();
        repeat (busy_to - cyc + 3) @(posedge clk);
        #1;
        check("drained", sig_q.size() + coef_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_signal"}, bus.signal_fifo, 0);
        check({tag, "_coeff"}, bus.coeff_fifo, 0);
        check({tag, "_sig_wr"}, bus.signal_wr_o, 0);
        check({tag, "_coef_wr"}, bus.coeff_wr_o, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_done"}, bus.done_o, 0);
        check({tag, "_nan"}, bus.nan_drop_o, 0);
    endtask

    initial begin
        int t1_e0;
        rstn = 1'b0;
        bus.sample_i = '0; bus.sample_valid_i = 1'b0; bus.sample_last_i = 1'b0; bus.mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk); #3 rstn = 1'b1;

        // Five-sample SeLU burst
        clear_obs();
        bus.mode = 1'b0;
        for (int i = 0; i < 5; i++) send(T1_VEC[i], i == 4);
        t1_e0 = e0;
        settle();
        check("t1_latency", done_seen - t1_e0, 18);
        check("t1_sig_count", obs_sig_n, 6);
        check("t1_coef_count", obs_coef.size(), 11);
        check("t1_coef0", obs_coef[0], 32'h3493F27D);
        check("t1_coef_sent", obs_coef[10], 32'h7F900000);

        // Single-sample TanH burst
        clear_obs();
        bus.mode = 1'b1;
        send(32'h41C80000, 1'b1);
        settle();
        check("t2_sig_count", obs_sig_n, 2);
        check("t2_coef0", obs_coef[0], 32'h2317A4DB);
        check("t2_coef9", obs_coef[9], 32'h3F800000);

        // Mode flips right after the closing accept
        clear_obs();
        bus.mode = 1'b1;
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        bus.mode = 1'b0;
        settle();
        check("t3_coef0", obs_coef[0], 32'h2317A4DB);

        // Full buffer closes without last
        clear_obs();
        for (int i = 0; i < 32; i++) send(32'h3F800000 + 32'(i) * 32'h100, 1'b0);
        @(negedge clk);
        check("t4_ready_drop", bus.sample_ready_o, 0);
        settle();
        check("t4_sig_count", obs_sig_n, 33);

        // NaN dropped mid-burst, then NaN-with-last on an empty buffer
        clear_obs();
        send(32'h40400000, 1'b0);
        send(32'h7F900000, 1'b0);
        send(32'h40800000, 1'b1);
        settle();
        check("t5_nan_count", obs_nan_n, 1);
        check("t5_sig_count", obs_sig_n, 3);
        clear_obs();
        send(32'h7FC00001, 1'b1);
        repeat (3) @(negedge clk);
        check("t5_stay_idle", bus.busy_o, 0);
        check("t5_nan2_count", obs_nan_n, 1);
        send(32'h41000000, 1'b1);
        settle();
        check("t5_after_sig_count", obs_sig_n, 2);

        // Reset while coefficients are streaming, then a fresh burst
        bus.mode = 1'b0;
        send(32'h40A00000, 1'b0);
        send(32'h40C00000, 1'b0);
        send(32'h40E00000, 1'b1);
        repeat (6) @(posedge clk);
        #3 rstn = 1'b0;
        model_reset();
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        clear_obs();
        bus.mode = 1'b1;
        send(32'h3E800000, 1'b0);
        send(32'h3F000000, 1'b1);
        settle();
        check("t6_sig_count", obs_sig_n, 3);
        check("t6_coef0", obs_coef[0], 32'h2317A4DB);
        check("t6_coef_sent", obs_coef[10], 32'h7F900000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
